// File: rtl/audio_pkg.sv
// Shared types and helpers for the stereo frame buffer: frame layout, buffer state
// and the saturating counter increment.
package audio_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int COUNTER_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } stereo_frame_t;

    typedef enum logic {
        PRIME,
        STREAM
    } buf_state_t;

    // Debug counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Plain circular frame store with read/write pointers and occupancy count.
// It only enforces structural legality; drop/stall decisions belong to the caller.
module frame_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 PTR_WIDTH  = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A push into a full store is legal only when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stereo_frame_fifo.sv
// Pairs left/right ADC samples into frames, buffers them, and releases them to the
// DAC channels once a priming level is reached; tracks dropped frames and underruns.
module stereo_frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int PRIME_LEVEL    = 4,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    adc_left_data,
    input  logic                     adc_left_valid,
    output logic                     adc_left_ready,
    input  logic [DATA_WIDTH-1:0]    adc_right_data,
    input  logic                     adc_right_valid,
    output logic                     adc_right_ready,
    output logic [DATA_WIDTH-1:0]    dac_left_data,
    output logic                     dac_left_valid,
    input  logic                     dac_left_ready,
    output logic [DATA_WIDTH-1:0]    dac_right_data,
    output logic                     dac_right_valid,
    input  logic                     dac_right_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              overflow_count,
    output logic [15:0]              underrun_count,
    output logic                     streaming
);

    localparam int                   COUNT_WIDTH = $clog2(DEPTH) + 1;
    localparam logic [COUNT_WIDTH-1:0] PRIME_COUNT = COUNT_WIDTH'(PRIME_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] ONE_FRAME   = COUNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  hold_l;
    logic [DATA_WIDTH-1:0]  hold_r;
    logic                   hold_l_full;
    logic                   hold_r_full;
    logic                   hold_l_full_next;
    logic                   hold_r_full_next;
    logic                   left_take;
    logic                   right_take;
    logic                   frame_done;
    logic                   frame_clear;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [COUNT_WIDTH-1:0] count;
    stereo_frame_t          push_frame;
    stereo_frame_t          head_frame;
    logic                   sent_l;
    logic                   sent_r;
    logic                   done_l;
    logic                   done_r;
    logic                   head_offered;
    logic                   going_prime;
    buf_state_t             state;
    buf_state_t             state_next;

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(stereo_frame_t))
    ) u_frame_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (push_frame),
        .rd_data (head_frame),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign left_take   = adc_left_valid && adc_left_ready;
    assign right_take  = adc_right_valid && adc_right_ready;
    assign frame_done  = hold_l_full && hold_r_full;
    assign push_frame  = stereo_frame_t'{left: hold_l, right: hold_r};

    // A completed frame either enters the store, is discarded, or waits in the holding registers.
    assign push        = frame_done && (!fifo_full || pop);
    assign drop        = DROP_WHEN_FULL && frame_done && fifo_full && !pop;
    assign frame_clear = push || drop;

    assign hold_l_full_next = (hold_l_full && !frame_clear) || left_take;
    assign hold_r_full_next = (hold_r_full && !frame_clear) || right_take;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_l          <= '0;
            hold_r          <= '0;
            hold_l_full     <= 1'b0;
            hold_r_full     <= 1'b0;
            adc_left_ready  <= 1'b0;
            adc_right_ready <= 1'b0;
        end else begin
            if (left_take) begin
                hold_l <= adc_left_data;
            end
            if (right_take) begin
                hold_r <= adc_right_data;
            end
            hold_l_full     <= hold_l_full_next;
            hold_r_full     <= hold_r_full_next;
            adc_left_ready  <= !hold_l_full_next;
            adc_right_ready <= !hold_r_full_next;
        end
    end

    // Each DAC channel takes the head sample on its own; the frame leaves once both have it.
    assign head_offered    = (state == STREAM) && !fifo_empty;
    assign dac_left_valid  = head_offered && !sent_l;
    assign dac_right_valid = head_offered && !sent_r;
    assign dac_left_data   = head_frame.left;
    assign dac_right_data  = head_frame.right;
    assign done_l          = sent_l || (dac_left_valid && dac_left_ready);
    assign done_r          = sent_r || (dac_right_valid && dac_right_ready);
    assign pop             = head_offered && done_l && done_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sent_l <= 1'b0;
            sent_r <= 1'b0;
        end else if (pop) begin
            sent_l <= 1'b0;
            sent_r <= 1'b0;
        end else begin
            sent_l <= done_l;
            sent_r <= done_r;
        end
    end

    always_comb begin
        state_next  = state;
        going_prime = 1'b0;
        case (state)
            PRIME: begin
                if (count >= PRIME_COUNT) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // Only the pop that empties the store with nothing arriving counts as an underrun.
                if (pop && !push && (count == ONE_FRAME)) begin
                    state_next  = PRIME;
                    going_prime = 1'b1;
                end
            end
            default: state_next = PRIME;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= PRIME;
            overflow_count <= '0;
            underrun_count <= '0;
        end else begin
            state <= state_next;
            if (drop) begin
                overflow_count <= sat_inc(overflow_count);
            end
            if (going_prime) begin
                underrun_count <= sat_inc(underrun_count);
            end
        end
    end

    assign fill_level = count;
    assign streaming  = (state == STREAM);

endmodule

// File: tb/tb_stereo_frame_fifo.sv
// Directed self-checking bench for stereo_frame_fifo: priming, pairing, overflow drops,
// independent DAC handshakes, underrun accounting and asynchronous reset.
module tb_stereo_frame_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] adc_left_data;
    logic        adc_left_valid;
    logic        adc_left_ready;
    logic [31:0] adc_right_data;
    logic        adc_right_valid;
    logic        adc_right_ready;
    logic [31:0] dac_left_data;
    logic        dac_left_valid;
    logic        dac_left_ready;
    logic [31:0] dac_right_data;
    logic        dac_right_valid;
    logic        dac_right_ready;
    logic [3:0]  fill_level;
    logic [15:0] overflow_count;
    logic [15:0] underrun_count;
    logic        streaming;

    int error_count = 0;
    int check_count = 0;

    always #5 clock = ~clock;

    stereo_frame_fifo #(
        .DEPTH          (8),
        .PRIME_LEVEL    (4),
        .DROP_WHEN_FULL (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .adc_left_data   (adc_left_data),
        .adc_left_valid  (adc_left_valid),
        .adc_left_ready  (adc_left_ready),
        .adc_right_data  (adc_right_data),
        .adc_right_valid (adc_right_valid),
        .adc_right_ready (adc_right_ready),
        .dac_left_data   (dac_left_data),
        .dac_left_valid  (dac_left_valid),
        .dac_left_ready  (dac_left_ready),
        .dac_right_data  (dac_right_data),
        .dac_right_valid (dac_right_valid),
        .dac_right_ready (dac_right_ready),
        .fill_level      (fill_level),
        .overflow_count  (overflow_count),
        .underrun_count  (underrun_count),
        .streaming       (streaming)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input logic need_l, input logic need_r);
        int n = 0;
        while (((need_l && !adc_left_ready) || (need_r && !adc_right_ready)) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checkOutput("ready_timeout", {62'd0, adc_left_ready, adc_right_ready}, {62'd0, need_l, need_r});
        end
    endtask

    // Offers one left/right pair in the same cycle; returns just after the capture edge.
    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r);
        wait_ready(1'b1, 1'b1);
        adc_left_data   = l;
        adc_right_data  = r;
        adc_left_valid  = 1'b1;
        adc_right_valid = 1'b1;
        tick();
        adc_left_valid  = 1'b0;
        adc_right_valid = 1'b0;
    endtask

    task automatic take_frame(input string tag, input logic [31:0] l, input logic [31:0] r);
        checkOutput({tag, "_lvalid"}, {63'd0, dac_left_valid}, 64'd1);
        checkOutput({tag, "_rvalid"}, {63'd0, dac_right_valid}, 64'd1);
        checkOutput({tag, "_ldata"}, {32'd0, dac_left_data}, {32'd0, l});
        checkOutput({tag, "_rdata"}, {32'd0, dac_right_data}, {32'd0, r});
        dac_left_ready  = 1'b1;
        dac_right_ready = 1'b1;
        tick();
        dac_left_ready  = 1'b0;
        dac_right_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] v;
        reset           = 1'b0;
        adc_left_data   = '0;
        adc_left_valid  = 1'b0;
        adc_right_data  = '0;
        adc_right_valid = 1'b0;
        dac_left_ready  = 1'b0;
        dac_right_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_lready", {63'd0, adc_left_ready}, 64'd0);
        checkOutput("rst_rready", {63'd0, adc_right_ready}, 64'd0);
        checkOutput("rst_lvalid", {63'd0, dac_left_valid}, 64'd0);
        checkOutput("rst_rvalid", {63'd0, dac_right_valid}, 64'd0);
        checkOutput("rst_fill", {60'd0, fill_level}, 64'd0);
        checkOutput("rst_stream", {63'd0, streaming}, 64'd0);
        checkOutput("rst_ovf", {48'd0, overflow_count}, 64'd0);
        checkOutput("rst_und", {48'd0, underrun_count}, 64'd0);

        reset = 1'b1;
        tick();
        checkOutput("ready_after_reset", {62'd0, adc_left_ready, adc_right_ready}, 64'd3);

        // Priming: three frames stay hidden, the fourth starts the stream.
        for (int i = 0; i < 3; i++) begin
            v = 32'(i);
            applyStimulus(v, ~v);
        end
        tick();
        checkOutput("t1_fill3", {60'd0, fill_level}, 64'd3);
        checkOutput("t1_lvalid_prime", {63'd0, dac_left_valid}, 64'd0);
        checkOutput("t1_rvalid_prime", {63'd0, dac_right_valid}, 64'd0);
        checkOutput("t1_stream_prime", {63'd0, streaming}, 64'd0);
        applyStimulus(32'd3, ~32'd3);
        tick();
        checkOutput("t1_fill4", {60'd0, fill_level}, 64'd4);
        checkOutput("t1_stream_lag", {63'd0, streaming}, 64'd0);
        tick();
        checkOutput("t1_stream", {63'd0, streaming}, 64'd1);
        tick();
        checkOutput("t1_hold_valid", {63'd0, dac_left_valid}, 64'd1);
        checkOutput("t1_hold_data", {32'd0, dac_left_data}, 64'd0);
        take_frame("t1_f0", 32'd0, 32'hFFFF_FFFF);
        take_frame("t1_f1", 32'd1, 32'hFFFF_FFFE);
        checkOutput("t1_fill2", {60'd0, fill_level}, 64'd2);

        // Right sample arrives well before its left partner.
        adc_right_data  = 32'hAAAA_0001;
        adc_right_valid = 1'b1;
        tick();
        adc_right_valid = 1'b0;
        repeat (5) tick();
        checkOutput("t2_rready_wait", {63'd0, adc_right_ready}, 64'd0);
        checkOutput("t2_lready_wait", {63'd0, adc_left_ready}, 64'd1);
        checkOutput("t2_fill_wait", {60'd0, fill_level}, 64'd2);
        adc_left_data  = 32'h5555_0002;
        adc_left_valid = 1'b1;
        tick();
        adc_left_valid = 1'b0;
        checkOutput("t2_rready_pend", {63'd0, adc_right_ready}, 64'd0);
        tick();
        checkOutput("t2_fill3", {60'd0, fill_level}, 64'd3);
        checkOutput("t2_rready_free", {63'd0, adc_right_ready}, 64'd1);

        // Fill to capacity with the DAC stalled, then overflow twice.
        for (int i = 10; i < 15; i++) begin
            v = 32'(i);
            applyStimulus(v, ~v);
        end
        tick();
        checkOutput("t3_fill8", {60'd0, fill_level}, 64'd8);
        applyStimulus(32'd20, ~32'd20);
        applyStimulus(32'd21, ~32'd21);
        tick();
        checkOutput("t3_ovf", {48'd0, overflow_count}, 64'd2);
        checkOutput("t3_fill_full", {60'd0, fill_level}, 64'd8);
        checkOutput("t3_head_l", {32'd0, dac_left_data}, 64'd2);
        checkOutput("t3_head_r", {32'd0, dac_right_data}, 64'hFFFF_FFFD);

        // Right channel accepts alone; the frame stays until left also takes it.
        dac_left_ready  = 1'b0;
        dac_right_ready = 1'b1;
        repeat (3) tick();
        checkOutput("t4_rvalid_drop", {63'd0, dac_right_valid}, 64'd0);
        checkOutput("t4_lvalid_hold", {63'd0, dac_left_valid}, 64'd1);
        checkOutput("t4_fill_nopop", {60'd0, fill_level}, 64'd8);
        dac_right_ready = 1'b0;
        dac_left_ready  = 1'b1;
        tick();
        dac_left_ready  = 1'b0;
        checkOutput("t4_fill_pop", {60'd0, fill_level}, 64'd7);
        checkOutput("t4_rvalid_next", {63'd0, dac_right_valid}, 64'd1);
        checkOutput("t4_head_next", {32'd0, dac_left_data}, 64'd3);

        // Drain to empty: stream stops and one underrun is recorded.
        take_frame("t5_f3", 32'd3, ~32'd3);
        take_frame("t5_fpair", 32'h5555_0002, 32'hAAAA_0001);
        for (int i = 10; i < 15; i++) begin
            v = 32'(i);
            take_frame("t5_drain", v, ~v);
        end
        checkOutput("t5_stream_off", {63'd0, streaming}, 64'd0);
        checkOutput("t5_und", {48'd0, underrun_count}, 64'd1);
        checkOutput("t5_lvalid_off", {63'd0, dac_left_valid}, 64'd0);
        checkOutput("t5_rvalid_off", {63'd0, dac_right_valid}, 64'd0);
        checkOutput("t5_fill0", {60'd0, fill_level}, 64'd0);

        // Re-prime, drain to one frame, then push and pop on the same edge.
        for (int i = 40; i < 44; i++) begin
            v = 32'(i);
            applyStimulus(v, ~v);
        end
        tick();
        tick();
        checkOutput("t5_restream", {63'd0, streaming}, 64'd1);
        for (int i = 40; i < 43; i++) begin
            v = 32'(i);
            take_frame("t5_refill", v, ~v);
        end
        checkOutput("t5_fill1", {60'd0, fill_level}, 64'd1);
        applyStimulus(32'd30, ~32'd30);
        take_frame("t5_f43", 32'd43, ~32'd43);
        checkOutput("t5_pp_fill", {60'd0, fill_level}, 64'd1);
        checkOutput("t5_pp_stream", {63'd0, streaming}, 64'd1);
        checkOutput("t5_pp_und", {48'd0, underrun_count}, 64'd1);
        checkOutput("t5_pp_head", {32'd0, dac_left_data}, 64'd30);

        // Asynchronous reset with stored frames and a half-built frame.
        for (int i = 50; i < 54; i++) begin
            v = 32'(i);
            applyStimulus(v, ~v);
        end
        tick();
        checkOutput("t6_fill5", {60'd0, fill_level}, 64'd5);
        adc_left_data  = 32'd77;
        adc_left_valid = 1'b1;
        tick();
        adc_left_valid = 1'b0;
        checkOutput("t6_lready_held", {63'd0, adc_left_ready}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6_lvalid", {63'd0, dac_left_valid}, 64'd0);
        checkOutput("t6_rvalid", {63'd0, dac_right_valid}, 64'd0);
        checkOutput("t6_lready", {63'd0, adc_left_ready}, 64'd0);
        checkOutput("t6_rready", {63'd0, adc_right_ready}, 64'd0);
        checkOutput("t6_fill", {60'd0, fill_level}, 64'd0);
        checkOutput("t6_ovf", {48'd0, overflow_count}, 64'd0);
        checkOutput("t6_und", {48'd0, underrun_count}, 64'd0);
        checkOutput("t6_stream", {63'd0, streaming}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        checkOutput("t6_lready_after", {63'd0, adc_left_ready}, 64'd1);
        checkOutput("t6_fill_after", {60'd0, fill_level}, 64'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
